seq_detect_param: RTL and testbench

- Runtime-programmable serial bit-sequence detector; the generalised successor of the team's fixed-pattern FSM detectors (clk, rst, x in, z out).
- Pattern length is 1..MAX_LEN and the pattern is loadable at runtime.
- Supports overlapping and non-overlapping match modes, input qualification, and an optional match counter.
- Sits between a serial input source and control logic that consumes single-cycle match pulses.

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/seq_det_match.sv | 29 ++
 rtl/seq_detect_param.sv | 140 ++++++++++++++
 tb/tb_seq_detect_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
//   DEF_MAX_LEN / DEF_CNT_W : default pattern length limit and counter width
//   len_mask(len)           : mask with the low `len` bits set (MASK_W wide,
//                             callers truncate to their own pattern width)
package seq_det_pkg;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam int unsigned DEF_CNT_W   = 8;

    // Widest pattern the mask helper can describe; MAX_LEN must not exceed it.
    localparam int unsigned MASK_W      = 64;

    // Low-`len` ones; saturates to all ones for len >= MASK_W.
    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        if (len >= MASK_W) begin
            m = '1;
        end else begin
            m = (MASK_W'(1) << len) - MASK_W'(1);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Combinational masked comparator for the sequence detector.
// Ports:
//   hist_next_i : post-shift history, newest bit in bit 0
//   cfg_pat_i   : latched pattern, last pattern bit in bit 0
//   cfg_len_i   : latched pattern length
//   vcnt_next_i : post-shift count of valid history bits
//   hit_c       : low cfg_len bits agree and enough bits have been seen
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] hist_next_i,
    input  logic [MAX_LEN-1:0] cfg_pat_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic [LEN_W-1:0]   vcnt_next_i,
    output logic               hit_c
);

    logic [MAX_LEN-1:0] mask_c;

    // Bits above the programmed length never take part in the compare.
    assign mask_c = MAX_LEN'(len_mask(32'(cfg_len_i)));

    assign hit_c = (vcnt_next_i >= cfg_len_i) &&
                   (((hist_next_i ^ cfg_pat_i) & mask_c) == '0);

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-sequence detector.
// Optional feature macro: SEQ_DET_CNT_EN (match counter present when defined,
// otherwise match_cnt is tied to zero).
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   load      : latch pattern/pat_len/overlap, clear history (beats in_valid)
//   pattern   : pattern bits, pattern[pat_len-1] received first
//   pat_len   : pattern length, legal range 1..MAX_LEN
//   overlap   : 1 = overlapping matches, 0 = restart after each match
//   in_valid  : qualifies x
//   x         : serial data bit
//   z         : registered single-cycle match pulse
//   match_cnt : saturating match count
//   cfg_ok    : latched configuration is legal
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter  int unsigned CNT_W   = DEF_CNT_W,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               in_valid,
    input  logic               x,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_ok
);

    logic [MAX_LEN-1:0] hist_q,    hist_d;
    logic [LEN_W-1:0]   vcnt_q,    vcnt_d;
    logic [MAX_LEN-1:0] cfg_pat_q, cfg_pat_d;
    logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
    logic               cfg_ovl_q, cfg_ovl_d;
    logic               cfg_ok_q,  cfg_ok_d;
    logic               z_q,       z_d;

    logic [MAX_LEN-1:0] hist_next_c;
    logic [LEN_W-1:0]   vcnt_next_c;
    logic               hit_c;
    logic               match_c;

    // Post-shift view used by the comparator on an accept cycle.
    assign hist_next_c = {hist_q[MAX_LEN-2:0], x};
    assign vcnt_next_c = (vcnt_q == LEN_W'(MAX_LEN)) ? vcnt_q : vcnt_q + LEN_W'(1);

    seq_det_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_match (
        .hist_next_i (hist_next_c),
        .cfg_pat_i   (cfg_pat_q),
        .cfg_len_i   (cfg_len_q),
        .vcnt_next_i (vcnt_next_c),
        .hit_c       (hit_c)
    );

    // Only an accepted bit under a legal configuration can complete a match.
    assign match_c = in_valid && !load && cfg_ok_q && hit_c;

    // Next-state logic for configuration, history and pulse.
    always_comb begin
        hist_d    = hist_q;
        vcnt_d    = vcnt_q;
        cfg_pat_d = cfg_pat_q;
        cfg_len_d = cfg_len_q;
        cfg_ovl_d = cfg_ovl_q;
        cfg_ok_d  = cfg_ok_q;
        z_d       = 1'b0;

        if (load) begin
            cfg_pat_d = pattern;
            cfg_len_d = pat_len;
            cfg_ovl_d = overlap;
            cfg_ok_d  = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
            hist_d    = '0;
            vcnt_d    = '0;
        end else if (in_valid) begin
            hist_d = hist_next_c;
            // Non-overlap mode demands cfg_len fresh bits after each match.
            vcnt_d = (match_c && !cfg_ovl_q) ? '0 : vcnt_next_c;
            z_d    = match_c;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q    <= '0;
            vcnt_q    <= '0;
            cfg_pat_q <= '0;
            cfg_len_q <= '0;
            cfg_ovl_q <= 1'b0;
            cfg_ok_q  <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            vcnt_q    <= vcnt_d;
            cfg_pat_q <= cfg_pat_d;
            cfg_len_q <= cfg_len_d;
            cfg_ovl_q <= cfg_ovl_d;
            cfg_ok_q  <= cfg_ok_d;
            z_q       <= z_d;
        end
    end

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter; survives reloads, cleared only by reset.
    always_comb begin
        cnt_d = cnt_q;
        if (match_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

    assign z      = z_q;
    assign cfg_ok = cfg_ok_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               rst;
    logic               load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               in_valid;
    logic               x;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_ok;

    int checks   = 0;
    int failures = 0;
    int nm       = 0;

    seq_detect_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .pattern   (pattern),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .in_valid  (in_valid),
        .x         (x),
        .z         (z),
        .match_cnt (match_cnt),
        .cfg_ok    (cfg_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ecnt(input int n);
`ifdef SEQ_DET_CNT_EN
        return (n > 3) ? 32'd3 : 32'(n);
`else
        return (n >= 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // All stepping tasks start and end 1 time unit after a rising edge.
    task automatic do_load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ovl, input logic xb);
        load = 1'b1; pattern = pat; pat_len = len; overlap = ovl;
        in_valid = 1'b1; x = xb;
        @(posedge clk); #1;
        load = 1'b0; in_valid = 1'b0;
    endtask

    task automatic acc(input logic xb);
        in_valid = 1'b1; x = xb;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        nm = 0;
    endtask

    initial begin
        logic [6:0] bits;
        logic [6:0] ez;

        rst = 1'b0; load = 1'b0; pattern = '0; pat_len = '0; overlap = 1'b0;
        in_valid = 1'b0; x = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_cfg_ok", 32'(cfg_ok), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Not loaded yet: a stream must not match.
        acc(1'b1);
        chk("inert_z", 32'(z), 32'd0);

        // Overlapping 1011 on 1011011: hits after bits 4 and 7.
        do_load(8'b0000_1011, 4'd4, 1'b1, 1'b0);
        chk("t1_cfg_ok", 32'(cfg_ok), 32'd1);
        bits = 7'b1011011;
        ez   = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            acc(bits[i]);
            chk("t1_z", 32'(z), 32'(ez[i]));
        end
        nm += 2;
        chk("t1_cnt", 32'(match_cnt), ecnt(nm));
        idle();
        chk("t1_z_single", 32'(z), 32'd0);

        // Non-overlapping: only the first hit.
        do_load(8'b0000_1011, 4'd4, 1'b0, 1'b0);
        ez = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            acc(bits[i]);
            chk("t2_z", 32'(z), 32'(ez[i]));
        end
        nm += 1;
        chk("t2_cnt", 32'(match_cnt), ecnt(nm));

        // 101 with two idle cycles between bits.
        do_load(8'b0000_0101, 4'd3, 1'b1, 1'b0);
        acc(1'b1); chk("t3_z_b1", 32'(z), 32'd0);
        idle();    chk("t3_z_gap", 32'(z), 32'd0);
        idle();    chk("t3_z_gap", 32'(z), 32'd0);
        acc(1'b0); chk("t3_z_b2", 32'(z), 32'd0);
        idle();    chk("t3_z_gap", 32'(z), 32'd0);
        idle();    chk("t3_z_gap", 32'(z), 32'd0);
        acc(1'b1); chk("t3_z_b3", 32'(z), 32'd1);
        nm += 1;
        chk("t3_cnt", 32'(match_cnt), ecnt(nm));
        idle();    chk("t3_z_after", 32'(z), 32'd0);

        // Asynchronous reset in the middle of a partial match.
        do_load(8'b0000_1011, 4'd4, 1'b1, 1'b0);
        acc(1'b1); acc(1'b0); acc(1'b1);
        chk("t4_cfg_ok_pre", 32'(cfg_ok), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t4_async_z", 32'(z), 32'd0);
        chk("t4_async_cnt", 32'(match_cnt), 32'd0);
        chk("t4_async_cfg_ok", 32'(cfg_ok), 32'd0);
        nm = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        acc(1'b1); chk("t4_z_post", 32'(z), 32'd0);
        acc(1'b0); acc(1'b1); acc(1'b1);
        chk("t4_z_noload", 32'(z), 32'd0);
        chk("t4_cfg_ok_post", 32'(cfg_ok), 32'd0);

        // Reload mid-stream: the bit in the load cycle is discarded.
        do_load(8'b0000_1011, 4'd4, 1'b1, 1'b0);
        acc(1'b1); acc(1'b0); acc(1'b1);
        do_load(8'b0000_0011, 4'd2, 1'b1, 1'b1);
        chk("t5_load_z", 32'(z), 32'd0);
        chk("t5_cfg_ok", 32'(cfg_ok), 32'd1);
        acc(1'b1); chk("t5_z_first", 32'(z), 32'd0);
        acc(1'b1); chk("t5_z_second", 32'(z), 32'd1);
        nm += 1;
        chk("t5_cnt", 32'(match_cnt), ecnt(nm));

        // Illegal lengths never match.
        do_load(8'b0000_0000, 4'd0, 1'b1, 1'b0);
        chk("t6_len0_cfg_ok", 32'(cfg_ok), 32'd0);
        for (int i = 0; i < 3; i++) begin
            acc(1'b0);
            chk("t6_len0_z", 32'(z), 32'd0);
        end
        do_load(8'b0000_0000, 4'd9, 1'b1, 1'b0);
        chk("t6_len9_cfg_ok", 32'(cfg_ok), 32'd0);
        for (int i = 0; i < 10; i++) acc(1'b0);
        chk("t6_len9_z", 32'(z), 32'd0);
        chk("t6_cnt", 32'(match_cnt), ecnt(nm));

        // Full-length pattern at MAX_LEN.
        do_load(8'b1100_1010, 4'd8, 1'b1, 1'b0);
        bits = 7'b1100101;
        for (int i = 6; i >= 0; i--) begin
            acc(bits[i]);
            chk("t7_z_partial", 32'(z), 32'd0);
        end
        acc(1'b0); chk("t7_z_full", 32'(z), 32'd1);
        nm += 1;

        // Length-1 pattern: consecutive hits and counter saturation.
        rst_pulse();
        do_load(8'b0000_0001, 4'd1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            acc(1'b1);
            chk("t8_z", 32'(z), 32'd1);
            chk("t8_cnt", 32'(match_cnt), ecnt(i));
        end
        do_load(8'b0000_0001, 4'd1, 1'b1, 1'b1);
        chk("t8_load_z", 32'(z), 32'd0);
        chk("t8_cnt_kept", 32'(match_cnt), ecnt(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
